// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: filters reset requests and releases downstream reset domains
// one at a time, lowest index first, waiting on each domain's ready before the next.
module reset_seq_ctrl #(
    parameter int N_DOMAINS   = 3,
    parameter int MIN_WIDTH   = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rst_req,
    input  logic [N_DOMAINS-1:0] dom_ready,
    output logic [N_DOMAINS-1:0] dom_rst,
    output logic                 done,
    output logic                 glitch,
    output logic                 timeout_err
);

    localparam int REQ_W  = $clog2(MIN_WIDTH + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int IDX_W  = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [REQ_W-1:0]     REQ_MAX   = REQ_W'(MIN_WIDTH);
    localparam logic [REQ_W-1:0]     REQ_LAST  = REQ_W'(MIN_WIDTH - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(N_DOMAINS - 1);
    localparam logic [N_DOMAINS-1:0] ALL_ON    = {N_DOMAINS{1'b1}};
    localparam logic [N_DOMAINS-1:0] ONE       = N_DOMAINS'(1);

    localparam logic [2:0] S_HOLD  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  next_idx;
    logic [REQ_W-1:0]  req_cnt;
    logic [REQ_W-1:0]  req_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              req_hit;
    logic              req_act;
    logic              glitch_det;

    // req_hit fires once, on the sample that completes MIN_WIDTH highs; req_act
    // stays true for as long as that same request is held.
    always_comb begin
        req_hit    = rst_req && (req_cnt == REQ_LAST);
        req_act    = rst_req && (req_cnt >= REQ_LAST);
        glitch_det = !rst_req && (req_cnt != '0) && (req_cnt < REQ_MAX);
        next_idx   = idx + IDX_W'(1);
        if (!rst_req) begin
            req_cnt_nxt = '0;
        end else if (req_cnt == REQ_MAX) begin
            req_cnt_nxt = REQ_MAX;
        end else begin
            req_cnt_nxt = req_cnt + REQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HOLD;
            idx         <= '0;
            req_cnt     <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            dom_rst     <= ALL_ON;
            done        <= 1'b0;
            glitch      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            req_cnt <= req_cnt_nxt;
            glitch  <= glitch_det;
            // An accepted request aborts whatever is in flight and wins over timeout.
            if (req_hit) begin
                state    <= S_HOLD;
                idx      <= '0;
                hold_cnt <= '0;
                gap_cnt  <= '0;
                tmo_cnt  <= '0;
                dom_rst  <= ALL_ON;
                done     <= 1'b0;
            end else begin
                case (state)
                    S_HOLD: begin
                        dom_rst <= ALL_ON;
                        done    <= 1'b0;
                        if (req_act) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            tmo_cnt  <= '0;
                            idx      <= '0;
                            dom_rst  <= ALL_ON & ~ONE;
                            state    <= S_WAIT;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    S_WAIT: begin
                        if (dom_ready[idx]) begin
                            tmo_cnt <= '0;
                            gap_cnt <= '0;
                            if (idx == LAST_IDX) begin
                                done  <= 1'b1;
                                state <= S_RUN;
                            end else begin
                                state <= S_GAP;
                            end
                        end else if (tmo_cnt == TMO_LAST) begin
                            tmo_cnt     <= '0;
                            timeout_err <= 1'b1;
                            dom_rst     <= ALL_ON;
                            state       <= S_FAULT;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= '0;
                            tmo_cnt <= '0;
                            idx     <= next_idx;
                            dom_rst <= dom_rst & ~(ONE << next_idx);
                            state   <= S_WAIT;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    S_RUN: begin
                        dom_rst <= '0;
                        done    <= 1'b1;
                    end
                    S_FAULT: begin
                        dom_rst <= ALL_ON;
                        done    <= 1'b0;
                    end
                    default: begin
                        state   <= S_HOLD;
                        dom_rst <= ALL_ON;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
